alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold current contents
- flush  in  1  load bubble
- id_valid  in  1  decode slot holds an instruction
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  extended immediate
- id_alusrc_imm  in  1  B operand from immediate
- id_alufun  in  6  ALU function code
- id_sign  in  1  signed compare/overflow
- id_rs, id_rt, id_rd  in  5  source and destination register numbers
- id_regwrite  in  1  instruction writes id_rd
- exmem_regwrite  in  1  forwarding source 1 valid write
- exmem_rd  in  5  forwarding source 1 register
- exmem_result  in  32  forwarding source 1 data
- memwb_regwrite  in  1  forwarding source 2 valid write
- memwb_rd  in  5  forwarding source 2 register
- memwb_result  in  32  forwarding source 2 data
- alu_a, alu_b  out  32  ALU A/B operands
- alu_fun  out  6  ALU function code
- alu_sign  out  1  ALU sign
- ex_store_data  out  32  forwarded rt value
- ex_rd  out  5  destination register
- ex_regwrite  out  1  gated write enable
- ex_valid  out  1  slot valid
- fwd_a, fwd_b  out  2  forwarding select: 0 none, 1 exmem, 2 memwb

Function
REQ-003 SHALL hold one ID/EX pipeline register: valid, rs_data, rt_data, imm, alusrc_imm, alufun, sign, rs, rt, rd, regwrite.
REQ-004 Rising clk, flush=1: load bubble (valid=0, regwrite=0, alufun=000000, sign=0, rs=rt=rd=0, all data fields 0); flush SHALL take priority over stall.
REQ-005 Rising clk, flush=0, stall=1: hold all fields, except rs_data and rt_data SHALL be overwritten with the current forwarded values (REQ-008) so a producer retiring during the stall is not lost.
REQ-006 Rising clk, flush=0, stall=0: load all fields from id_* inputs; stored regwrite = id_regwrite AND id_valid.
REQ-007 Forwarded rs value (combinational): exmem_result if exmem_regwrite, exmem_rd!=0 and exmem_rd==rs; else memwb_result if memwb_regwrite, memwb_rd!=0 and memwb_rd==rs; else stored rs_data. Rt value identical, using rt.
REQ-008 Exmem SHALL win when both sources match; register 0 SHALL never be forwarded.
REQ-009 alu_a = forwarded rs value; ex_store_data = forwarded rt value.
REQ-010 alu_b = stored imm when alusrc_imm=1, else forwarded rt value; fwd_b SHALL read 0 when alusrc_imm=1.
REQ-011 fwd_a/fwd_b SHALL reflect the select used in REQ-007.
REQ-012 alu_fun, alu_sign, ex_rd, ex_regwrite and ex_valid SHALL come directly from stored fields; latency ID to outputs is exactly one clock.
REQ-013 Forwarding inputs SHALL affect outputs in the same cycle; a stored bubble SHALL present alu_a=alu_b=0.
REQ-014 ex_regwrite SHALL never be 1 while ex_valid=0.

Reset
REQ-015 Reset asserted SHALL immediately force the bubble state of REQ-004, independent of clk.
REQ-016 Reset SHALL override flush, stall and in-flight loads; the first load SHALL occur on the first rising clk after deassertion.

Verification
REQ-017 Load rs=3, rs_data=0x0000000F, no forwarding matches -> next cycle alu_a=0x0000000F, fwd_a=0.
REQ-018 Stored rs=5; exmem_rd=5, exmem_result=0xF111111F; memwb_rd=5, memwb_result=0x00000900; both regwrite=1 -> alu_a=0xF111111F, fwd_a=1.
REQ-019 Stored rt=0; exmem_rd=0, exmem_regwrite=1, exmem_result=0xFFFFFFFF -> alu_b = stored rt_data (0), fwd_b=0.
REQ-020 alusrc_imm=1, imm=0x000021A0, rt matches exmem -> alu_b=0x000021A0, fwd_b=0, ex_store_data=exmem_result.
REQ-021 stall=1 one cycle with memwb_rd=rs, memwb_result=0x000011F0; then memwb_regwrite=0 -> alu_a stays 0x000011F0 after the stall.
REQ-022 stall=1 and flush=1 together, then reset mid-operation -> flush gives bubble (ex_valid=0, ex_regwrite=0, alu_fun=000000); reset immediately forces the same bubble.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: the ID/EX pipeline register plus operand forwarding.
//
// Captures one decoded instruction per clock and presents the ALU operands,
// function code and write-back controls to the execute stage. Operands are
// forwarded combinationally from the EX/MEM and MEM/WB results. EX/MEM wins
// when both match, and register 0 is never forwarded.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stall, flush               hold current contents / load a bubble
//   id_*                       decoded instruction from the ID stage
//   exmem_*, memwb_*           forwarding sources (write enable, register, data)
//   alu_a, alu_b               ALU operands
//   alu_fun, alu_sign          ALU function code and signed mode
//   ex_store_data              forwarded rt value for stores
//   ex_rd, ex_regwrite         destination register and gated write enable
//   ex_valid                   slot holds a real instruction
//   fwd_a, fwd_b               forwarding select: 0 none, 1 exmem, 2 memwb
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alusrc_imm,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_regwrite,
    output logic        ex_valid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam logic [1:0] FwdNone  = 2'd0;
    localparam logic [1:0] FwdExmem = 2'd1;
    localparam logic [1:0] FwdMemwb = 2'd2;

    // ID/EX pipeline register
    logic        valid_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic        alusrc_imm_q;
    logic [5:0]  alufun_q;
    logic        sign_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic        regwrite_q;

    logic [1:0]  sel_rs;
    logic [1:0]  sel_rt;
    logic [31:0] fwd_rs_val;
    logic [31:0] fwd_rt_val;

    // Forwarding select for each source register; EX/MEM is the younger
    // result, so it is checked first.
    always_comb begin
        sel_rs = FwdNone;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
            sel_rs = FwdExmem;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
            sel_rs = FwdMemwb;
        end

        sel_rt = FwdNone;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
            sel_rt = FwdExmem;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
            sel_rt = FwdMemwb;
        end
    end

    always_comb begin
        fwd_rs_val = rs_data_q;
        case (sel_rs)
            FwdExmem: fwd_rs_val = exmem_result;
            FwdMemwb: fwd_rs_val = memwb_result;
            default:  fwd_rs_val = rs_data_q;
        endcase

        fwd_rt_val = rt_data_q;
        case (sel_rt)
            FwdExmem: fwd_rt_val = exmem_result;
            FwdMemwb: fwd_rt_val = memwb_result;
            default:  fwd_rt_val = rt_data_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            alusrc_imm_q <= 1'b0;
            alufun_q     <= 6'd0;
            sign_q       <= 1'b0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            regwrite_q   <= 1'b0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            alusrc_imm_q <= 1'b0;
            alufun_q     <= 6'd0;
            sign_q       <= 1'b0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            regwrite_q   <= 1'b0;
        end else if (stall) begin
            // Capture forwarded operands so a producer that retires while
            // we are stalled is not lost once it leaves the bypass network.
            rs_data_q <= fwd_rs_val;
            rt_data_q <= fwd_rt_val;
        end else begin
            valid_q      <= id_valid;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            alusrc_imm_q <= id_alusrc_imm;
            alufun_q     <= id_alufun;
            sign_q       <= id_sign;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rd_q         <= id_rd;
            regwrite_q   <= id_regwrite & id_valid;
        end
    end

    always_comb begin
        alu_a         = fwd_rs_val;
        alu_b         = alusrc_imm_q ? imm_q : fwd_rt_val;
        ex_store_data = fwd_rt_val;
        fwd_a         = sel_rs;
        fwd_b         = alusrc_imm_q ? FwdNone : sel_rt;
        alu_fun       = alufun_q;
        alu_sign      = sign_q;
        ex_rd         = rd_q;
        ex_regwrite   = regwrite_q;
        ex_valid      = valid_q;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        id_alusrc_imm;
    logic [5:0]  id_alufun;
    logic        id_sign;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_valid;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_alusrc_imm  (id_alusrc_imm),
        .id_alufun      (id_alufun),
        .id_sign        (id_sign),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_regwrite    (id_regwrite),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_fun        (alu_fun),
        .alu_sign       (alu_sign),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_valid       (ex_valid),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alusrc;
        logic [5:0]  fun;
        logic        sign;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        xrw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_st;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic        e_rw;
        logic        e_v;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic no_fwd();
        exmem_regwrite = 1'b0;
        exmem_rd       = 5'd0;
        exmem_result   = 32'd0;
        memwb_regwrite = 1'b0;
        memwb_rd       = 5'd0;
        memwb_result   = 32'd0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [31:0] rs_data,
                            input logic [4:0] rt, input logic [31:0] rt_data,
                            input logic [4:0] rd, input logic [5:0] fun);
        id_valid      = v;
        id_rs         = rs;
        id_rs_data    = rs_data;
        id_rt         = rt;
        id_rt_data    = rt_data;
        id_rd         = rd;
        id_alufun     = fun;
        id_imm        = 32'd0;
        id_alusrc_imm = 1'b0;
        id_sign       = 1'b0;
        id_regwrite   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000000F, 32'h00000022, 32'h0, 1'b0, 6'h20, 1'b1, 5'd3, 5'd4, 5'd7,
                    1'b1, 1'b1, 5'd9, 32'hDEAD0000, 1'b1, 5'd10, 32'h0BAD0000,
                    32'h0000000F, 32'h00000022, 32'h00000022, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'h00000011, 32'h00000066, 32'h0, 1'b0, 6'h22, 1'b0, 5'd5, 5'd6, 5'd8,
                    1'b1, 1'b1, 5'd5, 32'hF111111F, 1'b1, 5'd5, 32'h00000900,
                    32'hF111111F, 32'h00000066, 32'h00000066, 2'd1, 2'd0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 32'h00000010, 32'h00000000, 32'h0, 1'b0, 6'h24, 1'b1, 5'd1, 5'd0, 5'd9,
                    1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h00000123,
                    32'h00000010, 32'h00000000, 32'h00000000, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h00000007, 32'h00000005, 32'h000021A0, 1'b1, 6'h21, 1'b0, 5'd2, 5'd8,
                    5'd11, 1'b1, 1'b1, 5'd8, 32'hABCD0001, 1'b1, 5'd2, 32'h00003333,
                    32'h00003333, 32'h000021A0, 32'hABCD0001, 2'd2, 2'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h00000001, 32'h00000002, 32'h0, 1'b0, 6'h25, 1'b1, 5'd9, 5'd10, 5'd12,
                    1'b0, 1'b0, 5'd10, 32'h00000055, 1'b1, 5'd10, 32'h00000044,
                    32'h00000001, 32'h00000044, 32'h00000044, 2'd0, 2'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h00000003, 32'h00000004, 32'h0, 1'b0, 6'h26, 1'b0, 5'd1, 5'd2, 5'd13,
                    1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    32'h00000003, 32'h00000004, 32'h00000004, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h00000008, 32'h00000009, 32'h0, 1'b0, 6'h2A, 1'b1, 5'd12, 5'd13, 5'd14,
                    1'b1, 1'b0, 5'd12, 32'h00000077, 1'b1, 5'd12, 32'h00000088,
                    32'h00000088, 32'h00000009, 32'h00000009, 2'd2, 2'd0, 1'b1, 1'b1};

        // Reset state
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        no_fwd();
        drive_id(1'b1, 5'd1, 32'h12345678, 5'd2, 32'h9ABCDEF0, 5'd3, 6'h3F);
        #1;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("reset_alu_fun", {26'd0, alu_fun}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        tick();
        chk("reset_hold_valid", {31'd0, ex_valid}, 32'd0);
        reset = 1'b0;

        // Table-driven loads; forwarding is applied after the capturing edge
        for (int i = 0; i < 7; i++) begin
            no_fwd();
            id_valid      = vecs[i].valid;
            id_rs_data    = vecs[i].rs_data;
            id_rt_data    = vecs[i].rt_data;
            id_imm        = vecs[i].imm;
            id_alusrc_imm = vecs[i].alusrc;
            id_alufun     = vecs[i].fun;
            id_sign       = vecs[i].sign;
            id_rs         = vecs[i].rs;
            id_rt         = vecs[i].rt;
            id_rd         = vecs[i].rd;
            id_regwrite   = vecs[i].rw;
            tick();
            exmem_regwrite = vecs[i].xrw;
            exmem_rd       = vecs[i].xrd;
            exmem_result   = vecs[i].xres;
            memwb_regwrite = vecs[i].mrw;
            memwb_rd       = vecs[i].mrd;
            memwb_result   = vecs[i].mres;
            #1;
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_a);
            chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].e_b);
            chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].e_st);
            chk($sformatf("v%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].e_fa});
            chk($sformatf("v%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].e_fb});
            chk($sformatf("v%0d_regwrite", i), {31'd0, ex_regwrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d_alu_fun", i), {26'd0, alu_fun}, {26'd0, vecs[i].fun});
            chk($sformatf("v%0d_alu_sign", i), {31'd0, alu_sign}, {31'd0, vecs[i].sign});
            chk($sformatf("v%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
        end

        // Stall captures a forwarded MEM/WB value that then retires
        no_fwd();
        drive_id(1'b1, 5'd4, 32'h00000001, 5'd5, 32'h00000002, 5'd3, 6'h20);
        tick();
        stall          = 1'b1;
        memwb_regwrite = 1'b1;
        memwb_rd       = 5'd4;
        memwb_result   = 32'h000011F0;
        drive_id(1'b1, 5'd4, 32'h00000999, 5'd5, 32'h00000888, 5'd20, 6'h3F);
        #1;
        chk("stall_pre_alu_a", alu_a, 32'h000011F0);
        chk("stall_pre_fwd_a", {30'd0, fwd_a}, 32'd2);
        tick();
        memwb_regwrite = 1'b0;
        #1;
        chk("stall_post_alu_a", alu_a, 32'h000011F0);
        chk("stall_post_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("stall_post_alu_b", alu_b, 32'h00000002);
        chk("stall_hold_rd", {27'd0, ex_rd}, 32'd3);
        chk("stall_hold_fun", {26'd0, alu_fun}, 32'h20);

        // Flush wins over stall
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("flush_alu_fun", {26'd0, alu_fun}, 32'd0);
        chk("flush_alu_a", alu_a, 32'd0);
        chk("flush_alu_b", alu_b, 32'd0);
        chk("flush_ex_rd", {27'd0, ex_rd}, 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Reset mid-operation forces the bubble without a clock edge
        drive_id(1'b1, 5'd1, 32'h00000055, 5'd2, 32'h00000066, 5'd6, 6'h21);
        tick();
        chk("reload_valid", {31'd0, ex_valid}, 32'd1);
        chk("reload_alu_a", alu_a, 32'h00000055);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("async_rst_alu_fun", {26'd0, alu_fun}, 32'd0);
        chk("async_rst_alu_a", alu_a, 32'd0);
        tick();
        chk("rst_held_valid", {31'd0, ex_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_release_no_load", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_alu_a", alu_a, 32'h00000055);
        chk("post_rst_alu_fun", {26'd0, alu_fun}, 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
